// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: register offsets (word index),
// STATUS bit positions and the serialiser state encoding.
package uart_tx_pkg;

  localparam logic [9:0] REG_TXDATA = 10'd0;
  localparam logic [9:0] REG_STATUS = 10'd1;
  localparam logic [9:0] REG_BAUD   = 10'd2;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout_o is valid whenever empty_o is low.
// Pointers carry one extra wrap bit so level = wr - rd needs no special cases.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Full/empty come from registered pointers, so a same-cycle pop never admits a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, TX FIFO and a
// baud-counter driven serialiser. Read data returns one cycle after the command.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  input  logic        mem_cmd_wr,
  input  logic [11:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [9:0]  reg_idx;
  logic        wr_en, rd_en, push, pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_level;
  logic [31:0] status_word;
  logic        busy;
  logic        unused_bits;

  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic        rsp_q, rsp_d;
  logic [31:0] rdata_q, rdata_d;
  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;

  assign reg_idx     = mem_cmd_addr[11:2];
  assign wr_en       = mem_cmd_valid && mem_cmd_sel && mem_cmd_wr;
  assign rd_en       = mem_cmd_valid && mem_cmd_sel && !mem_cmd_wr;
  assign push        = wr_en && (reg_idx == REG_TXDATA);
  assign busy        = (state_q != TX_IDLE);
  assign unused_bits = ^{mem_cmd_addr[1:0], mem_cmd_wdata[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (mem_cmd_wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status_word               = '0;
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_EMPTY_BIT] = fifo_empty;
    status_word[ST_BUSY_BIT]  = busy;
    status_word[ST_OVF_BIT]   = ovf_q;
    status_word[15:8]         = 8'(fifo_level);
  end

  // Register writes and read mux; an overflow set beats a same-cycle clear.
  always_comb begin
    div_d   = div_q;
    ovf_d   = ovf_q;
    rsp_d   = rd_en;
    rdata_d = '0;
    if (wr_en && reg_idx == REG_BAUD) div_d = mem_cmd_wdata[15:0];
    if (wr_en && reg_idx == REG_STATUS && mem_cmd_wdata[ST_OVF_BIT]) ovf_d = 1'b0;
    if (push && fifo_full) ovf_d = 1'b1;
    if (rd_en) begin
      case (reg_idx)
        REG_STATUS: rdata_d = status_word;
        REG_BAUD:   rdata_d = {16'b0, div_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = div_q;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = div_q;
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = div_q;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // Line level follows the next state so the registered pin lines up with state_q.
    txd_d = 1'b1;
    if (state_d == TX_START) txd_d = 1'b0;
    else if (state_d == TX_DATA) txd_d = shift_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      rsp_q     <= 1'b0;
      rdata_q   <= '0;
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      rsp_q     <= rsp_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign mem_rsp_ready = rsp_q;
  assign mem_rsp_rdata = rdata_q;
  assign uart_txd      = txd_q;
  assign tx_irq        = fifo_empty && !busy;

endmodule
